// File: rtl/stack_flow_sequencer_if.sv
// Stack memory request/acknowledge port between the control-flow
// sequencer (master) and the stack memory (slave).
interface stack_flow_sequencer_if #(
  parameter int WORD_W = 16
);
  logic              req;
  logic              we;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/stack_flow_sequencer.sv
// Decode-stage control-flow sequencer: multi-cycle stack sequences
// for CALL, RET, RETI and prioritised interrupt entry.
module stack_flow_sequencer #(
  parameter int PC_W         = 32,
  parameter int WORD_W       = 16,
  parameter int FLAG_W       = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int NUM_IRQ      = 2,
  parameter int VEC_BASE     = 0,
  parameter int VEC_STRIDE   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_op_valid,
  input  logic [1:0]          i_op_code,
  input  logic [PC_W-1:0]     i_pc_in,
  input  logic [PC_W-1:0]     i_call_target,
  input  logic [FLAG_W-1:0]   i_flags_in,
  input  logic [NUM_IRQ-1:0]  i_irq_req,
  stack_flow_sequencer_if.master stk,
  output logic                o_stall_fetch,
  output logic                o_flush,
  output logic                o_pc_load,
  output logic [PC_W-1:0]     o_pc_load_val,
  output logic                o_flags_load,
  output logic [FLAG_W-1:0]   o_flags_load_val,
  output logic [NUM_IRQ-1:0]  o_irq_ack,
  output logic                o_busy
);

  localparam int NW    = PC_W / WORD_W;
  localparam int CMAX  = (DRAIN_CYCLES > NW) ? DRAIN_CYCLES : NW;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PC,
    S_PUSH_FLAGS,
    S_POP_FLAGS,
    S_POP_PC,
    S_LOAD_PC
  } state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     r_target;
  logic [FLAG_W-1:0]   r_flags;
  logic [IDX_W-1:0]    r_idx;
  logic                r_is_irq;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req;
  logic                r_we;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_flush;
  logic                r_pc_load;
  logic [PC_W-1:0]     r_pc_load_val;
  logic                r_flags_load;
  logic [FLAG_W-1:0]   r_flags_load_val;
  logic [NUM_IRQ-1:0]  r_irq_ack;

  logic                w_op;
  logic                w_call;
  logic                w_ret;
  logic                w_reti;
  logic                w_irq;
  logic [IDX_W-1:0]    w_irq_idx;
  logic                w_hs;
  logic [PC_W-1:0]     w_pc_shl;
  logic [PC_W-1:0]     w_pc_pop;
  logic [PC_W-1:0]     w_vec;

  assign w_op   = i_op_valid && (i_op_code != 2'b00);
  assign w_call = i_op_valid && (i_op_code == 2'b01);
  assign w_ret  = i_op_valid && (i_op_code == 2'b10);
  assign w_reti = i_op_valid && (i_op_code == 2'b11);
  assign w_irq  = !w_op && (|i_irq_req);
  assign w_hs   = r_req && stk.ack;

  // Push shifts the PC left so the next word is always on top;
  // pop shifts right so the last (most significant) word lands on top.
  assign w_pc_shl = r_pc << WORD_W;
  assign w_pc_pop = (r_pc >> WORD_W)
                  | (PC_W'(stk.rdata) << (PC_W - WORD_W));
  assign w_vec    = PC_W'(VEC_BASE)
                  + PC_W'(r_idx) * PC_W'(VEC_STRIDE);

  // Lowest set request index wins.
  always_comb begin
    w_irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_irq_req[i]) w_irq_idx = IDX_W'(i);
    end
  end

  // Sequencer state, latched context and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_pc             <= '0;
      r_target         <= '0;
      r_flags          <= '0;
      r_idx            <= '0;
      r_is_irq         <= 1'b0;
      r_cnt            <= '0;
      r_req            <= 1'b0;
      r_we             <= 1'b0;
      r_wdata          <= '0;
      r_flush          <= 1'b0;
      r_pc_load        <= 1'b0;
      r_pc_load_val    <= '0;
      r_flags_load     <= 1'b0;
      r_flags_load_val <= '0;
      r_irq_ack        <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_call: begin
              r_pc     <= i_pc_in;
              r_target <= i_call_target;
              r_is_irq <= 1'b0;
              r_state  <= S_PUSH_PC;
              r_req    <= 1'b1;
              r_we     <= 1'b1;
              r_wdata  <= i_pc_in[PC_W-1 -: WORD_W];
              r_cnt    <= CNT_W'(NW - 1);
            end
            w_ret: begin
              r_is_irq <= 1'b0;
              r_state  <= S_POP_PC;
              r_req    <= 1'b1;
              r_we     <= 1'b0;
              r_wdata  <= '0;
              r_cnt    <= CNT_W'(NW - 1);
            end
            w_reti: begin
              r_is_irq <= 1'b0;
              r_state  <= S_POP_FLAGS;
              r_req    <= 1'b1;
              r_we     <= 1'b0;
              r_wdata  <= '0;
            end
            w_irq: begin
              r_pc     <= i_pc_in;
              r_flags  <= i_flags_in;
              r_idx    <= w_irq_idx;
              r_is_irq <= 1'b1;
              if (DRAIN_CYCLES == 0) begin
                r_state <= S_PUSH_PC;
                r_req   <= 1'b1;
                r_we    <= 1'b1;
                r_wdata <= i_pc_in[PC_W-1 -: WORD_W];
                r_cnt   <= CNT_W'(NW - 1);
              end else begin
                r_state <= S_DRAIN;
                r_flush <= 1'b1;
                r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
              end
            end
            default: ;
          endcase
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_flush <= 1'b0;
            r_state <= S_PUSH_PC;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_wdata <= r_pc[PC_W-1 -: WORD_W];
            r_cnt   <= CNT_W'(NW - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_PUSH_PC: begin
          if (w_hs) begin
            r_pc <= w_pc_shl;
            if (r_cnt == '0) begin
              if (r_is_irq) begin
                r_state <= S_PUSH_FLAGS;
                r_wdata <= WORD_W'(r_flags);
              end else begin
                r_state       <= S_LOAD_PC;
                r_req         <= 1'b0;
                r_we          <= 1'b0;
                r_wdata       <= '0;
                r_pc_load     <= 1'b1;
                r_pc_load_val <= r_target;
              end
            end else begin
              r_cnt   <= r_cnt - CNT_W'(1);
              r_wdata <= w_pc_shl[PC_W-1 -: WORD_W];
            end
          end
        end
        S_PUSH_FLAGS: begin
          if (w_hs) begin
            r_state       <= S_LOAD_PC;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_pc_load     <= 1'b1;
            r_pc_load_val <= w_vec;
            r_irq_ack     <= NUM_IRQ'(1) << r_idx;
          end
        end
        S_POP_FLAGS: begin
          if (w_hs) begin
            r_req            <= 1'b0;
            r_flags_load     <= 1'b1;
            r_flags_load_val <= stk.rdata[FLAG_W-1:0];
          end else if (r_flags_load) begin
            r_flags_load     <= 1'b0;
            r_flags_load_val <= '0;
            r_state          <= S_POP_PC;
            r_req            <= 1'b1;
            r_we             <= 1'b0;
            r_cnt            <= CNT_W'(NW - 1);
          end
        end
        S_POP_PC: begin
          if (w_hs) begin
            r_pc <= w_pc_pop;
            if (r_cnt == '0) begin
              r_state       <= S_LOAD_PC;
              r_req         <= 1'b0;
              r_pc_load     <= 1'b1;
              r_pc_load_val <= w_pc_pop;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        S_LOAD_PC: begin
          r_state       <= S_IDLE;
          r_pc_load     <= 1'b0;
          r_pc_load_val <= '0;
          r_irq_ack     <= '0;
          r_is_irq      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stk.req          = r_req;
  assign stk.we           = r_we;
  assign stk.wdata        = r_wdata;
  assign o_busy           = (r_state != S_IDLE);
  assign o_stall_fetch    = (r_state != S_IDLE);
  assign o_flush          = r_flush;
  assign o_pc_load        = r_pc_load;
  assign o_pc_load_val    = r_pc_load_val;
  assign o_flags_load     = r_flags_load;
  assign o_flags_load_val = r_flags_load_val;
  assign o_irq_ack        = r_irq_ack;

endmodule

// File: tb/tb_stack_flow_sequencer.sv
// Scoreboard bench for stack_flow_sequencer: a stack memory model
// answers the req/ack port, expected traffic is queued up front.
module tb_stack_flow_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] pc_in = '0;
  logic [31:0] call_target = '0;
  logic [3:0]  flags_in = '0;
  logic [1:0]  irq_req = '0;
  logic        o_stall_fetch;
  logic        o_flush;
  logic        o_pc_load;
  logic [31:0] o_pc_load_val;
  logic        o_flags_load;
  logic [3:0]  o_flags_load_val;
  logic [1:0]  o_irq_ack;
  logic        o_busy;

  stack_flow_sequencer_if #(.WORD_W(16)) stk ();

  stack_flow_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .i_op_valid       (op_valid),
    .i_op_code        (op_code),
    .i_pc_in          (pc_in),
    .i_call_target    (call_target),
    .i_flags_in       (flags_in),
    .i_irq_req        (irq_req),
    .stk              (stk),
    .o_stall_fetch    (o_stall_fetch),
    .o_flush          (o_flush),
    .o_pc_load        (o_pc_load),
    .o_pc_load_val    (o_pc_load_val),
    .o_flags_load     (o_flags_load),
    .o_flags_load_val (o_flags_load_val),
    .o_irq_ack        (o_irq_ack),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] d;
  } stk_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ack;
  } pcl_t;

  stk_t        q_stk[$];
  pcl_t        q_pc[$];
  logic [3:0]  q_flg[$];
  logic [15:0] mem [16];
  int          sp = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          spur = 1'b0;
  int          busy_cyc = 0;
  int          flush_cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;
  logic        prev_req = 1'b0;
  logic        prev_we = 1'b0;
  logic [15:0] prev_wd = '0;
  stk_t        m_e;
  pcl_t        m_p;
  logic [3:0]  m_f;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_stk(input logic we, input logic [15:0] d);
    stk_t e;
    e.we = we;
    e.d  = d;
    q_stk.push_back(e);
  endtask

  task automatic exp_pc(input logic [31:0] pc, input logic [1:0] ack);
    pcl_t p;
    p.pc  = pc;
    p.ack = ack;
    q_pc.push_back(p);
  endtask

  // Monitor and stack memory model, both on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      stk.ack  = 1'b0;
      wait_cnt = 0;
      prev_req = 1'b0;
    end else begin
      if (o_busy !== o_stall_fetch)
        check("stall_eq_busy", o_stall_fetch, o_busy);
      if (o_busy) busy_cyc++;
      if (o_flush) flush_cyc++;
      if (prev_req && !stk.ack) begin
        check("hold_req", stk.req, 1);
        check("hold_we", stk.we, prev_we);
        check("hold_wdata", stk.wdata, prev_wd);
      end
      if (o_pc_load) begin
        if (q_pc.size() == 0) begin
          check("pc_load_unexpected", 1, 0);
        end else begin
          m_p = q_pc.pop_front();
          check("pc_load_val", o_pc_load_val, m_p.pc);
          check("irq_ack", o_irq_ack, m_p.ack);
        end
      end
      if (o_irq_ack != 2'b00 && !o_pc_load)
        check("irq_ack_without_pc_load", o_pc_load, 1);
      if (o_flags_load) begin
        if (q_flg.size() == 0) begin
          check("flags_load_unexpected", 1, 0);
        end else begin
          m_f = q_flg.pop_front();
          check("flags_load_val", o_flags_load_val, m_f);
        end
      end
      irq_req = irq_req & ~o_irq_ack;
      prev_req = stk.req;
      prev_we  = stk.we;
      prev_wd  = stk.wdata;
      stk.ack  = 1'b0;
      if (stk.req) begin
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          stk.ack  = 1'b1;
          if (q_stk.size() == 0) begin
            check("stack_unexpected", 1, 0);
          end else begin
            m_e = q_stk.pop_front();
            check("stack_we", stk.we, m_e.we);
            if (m_e.we) check("stack_wdata", stk.wdata, m_e.d);
          end
          if (stk.we) begin
            mem[sp[3:0]] = stk.wdata;
            sp++;
          end else begin
            if (sp > 0) sp--;
            stk.rdata = mem[sp[3:0]];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spur) begin
          stk.ack   = 1'b1;
          stk.rdata = 16'hDEAD;
        end
      end
    end
  end

  task automatic start(input logic v, input logic [1:0] code,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [1:0] irq, input logic [3:0] fl);
    op_valid    = v;
    op_code     = code;
    pc_in       = pc;
    call_target = tgt;
    irq_req     = irq;
    flags_in    = fl;
    busy_cyc    = 0;
    flush_cyc   = 0;
    @(posedge clk); #1;
    op_valid    = 1'b0;
    op_code     = 2'b00;
    pc_in       = 32'hDEAD_BEEF;
    call_target = 32'hBAD0_BAD0;
    flags_in    = 4'h5;
  endtask

  task automatic wait_idle(input string tag, input int exp_busy);
    int n = 0;
    while (o_busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_busy) check({tag, "_timeout"}, 1, 0);
    check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_stall"}, o_stall_fetch, 0);
    check({tag, "_req"}, stk.req, 0);
    check({tag, "_we"}, stk.we, 0);
    check({tag, "_wdata"}, stk.wdata, 0);
    check({tag, "_flush"}, o_flush, 0);
    check({tag, "_pc_load"}, {o_pc_load, o_pc_load_val}, 0);
    check({tag, "_flags_load"}, {o_flags_load, o_flags_load_val}, 0);
    check({tag, "_irq_ack"}, o_irq_ack, 0);
  endtask

  initial begin
    stk.ack   = 1'b0;
    stk.rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    exp_stk(1'b1, 16'h0001);
    exp_stk(1'b1, 16'h2345);
    exp_pc(32'h0000_0100, 2'b00);
    start(1'b1, 2'b01, 32'h0001_2345, 32'h0000_0100, 2'b00, 4'h0);
    wait_idle("call", 3);

    ack_delay = 3;
    exp_stk(1'b0, 16'h0000);
    exp_stk(1'b0, 16'h0000);
    exp_pc(32'h0001_2345, 2'b00);
    start(1'b1, 2'b10, 32'h0, 32'h0, 2'b00, 4'h0);
    wait_idle("ret_slow", 9);
    ack_delay = 0;

    exp_stk(1'b1, 16'h0000);
    exp_stk(1'b1, 16'h0040);
    exp_stk(1'b1, 16'h000A);
    exp_pc(32'h0000_0000, 2'b01);
    start(1'b0, 2'b00, 32'h0000_0040, 32'h0, 2'b11, 4'hA);
    irq_req = 2'b00;
    wait_idle("irq0", 8);
    check("irq0_flush_cycles", flush_cyc, 4);

    spur = 1'b1;
    exp_stk(1'b0, 16'h0000);
    exp_stk(1'b0, 16'h0000);
    exp_stk(1'b0, 16'h0000);
    q_flg.push_back(4'hA);
    exp_pc(32'h0000_0040, 2'b00);
    start(1'b1, 2'b11, 32'h0, 32'h0, 2'b00, 4'h0);
    wait_idle("reti", 5);
    spur = 1'b0;

    exp_stk(1'b1, 16'h0000);
    exp_stk(1'b1, 16'h0104);
    exp_pc(32'h0000_0200, 2'b00);
    exp_stk(1'b1, 16'h0000);
    exp_stk(1'b1, 16'h0500);
    exp_stk(1'b1, 16'h0003);
    exp_pc(32'h0000_0002, 2'b10);
    start(1'b1, 2'b01, 32'h0000_0104, 32'h0000_0200, 2'b10, 4'h3);
    pc_in    = 32'h0000_0500;
    flags_in = 4'h3;
    wait_idle("call_first", 3);
    busy_cyc  = 0;
    flush_cyc = 0;
    @(posedge clk); #1;
    wait_idle("irq1_after_call", 8);
    check("irq1_flush_cycles", flush_cyc, 4);
    check("irq1_req_cleared", irq_req, 0);
    check("queues_empty_mid", q_stk.size() + q_pc.size() + q_flg.size(), 0);

    exp_stk(1'b1, 16'h0001);
    exp_stk(1'b1, 16'h2345);
    exp_pc(32'h0000_0100, 2'b00);
    start(1'b1, 2'b01, 32'h0001_2345, 32'h0000_0100, 2'b00, 4'h0);
    @(posedge clk); #1;
    check("pre_reset_req", stk.req, 1);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    op_valid = 1'b1;
    op_code  = 2'b01;
    irq_req  = 2'b01;
    repeat (3) begin
      @(posedge clk); #1;
      check("in_reset_busy", o_busy, 0);
      check("in_reset_irq_ack", o_irq_ack, 0);
    end
    op_valid = 1'b0;
    op_code  = 2'b00;
    irq_req  = 2'b00;
    q_stk.delete();
    q_pc.delete();
    q_flg.delete();
    sp = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", o_busy, 0);

    exp_stk(1'b1, 16'h0000);
    exp_stk(1'b1, 16'h0ABC);
    exp_pc(32'h0000_0777, 2'b00);
    start(1'b1, 2'b01, 32'h0000_0ABC, 32'h0000_0777, 2'b00, 4'h0);
    wait_idle("call_after_reset", 3);

    @(posedge clk); #1;
    check("queues_empty_end", q_stk.size() + q_pc.size() + q_flg.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_flow_sequencer.md
Name: stack_flow_sequencer

Overview:
- Parametrised control-flow sequencer in the decode stage. Runs the multi-cycle stack sequences for CALL, RET, RETI and hardware interrupts.
- Generalised from the fixed 32-bit PC / 16-bit word design:
  - configurable PC and stack-word widths, with PC split into PC_W/WORD_W words;
  - configurable pipeline drain depth;
  - NUM_IRQ prioritised interrupt sources, each with its own vector;
  - req/ack handshake to the stack memory port instead of fixed single-cycle pushes and pops.

Parameters:
PC_W, 32, program counter width; must be a multiple of WORD_W
WORD_W, 16, stack memory word width
FLAG_W, 4, flag register width; must be <= WORD_W
DRAIN_CYCLES, 4, flush cycles before an interrupt push sequence; 0 allowed
NUM_IRQ, 2, number of interrupt request lines; index 0 is highest priority
VEC_BASE, 0, PC of the interrupt 0 vector
VEC_STRIDE, 2, address distance between consecutive vectors

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
op_valid  in  1  decoded control-flow op present; sampled only in IDLE
op_code  in  2  00 none, 01 CALL, 10 RET, 11 RETI
pc_in  in  PC_W  return address (next PC); latched on acceptance
call_target  in  PC_W  CALL destination; latched on acceptance
flags_in  in  FLAG_W  current flags; latched on interrupt acceptance
irq_req  in  NUM_IRQ  level-sensitive interrupt requests
stack_req  out  1  stack transaction request
stack_we  out  1  1 = push, 0 = pop
stack_wdata  out  WORD_W  push data
stack_ack  in  1  transaction complete this cycle
stack_rdata  in  WORD_W  pop data; valid when stack_ack is high
stall_fetch  out  1  freeze PC and fetch
flush  out  1  inject NOP into pipeline
pc_load  out  1  one-cycle PC overwrite strobe
pc_load_val  out  PC_W  new PC
flags_load  out  1  one-cycle flag restore strobe
flags_load_val  out  FLAG_W  restored flags
irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge
busy  out  1  sequencer not in IDLE

Behaviour:
- States: IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, POP_FLAGS, POP_PC, LOAD_PC.
- Reset (reset=0, any cycle, including mid-sequence):
  - state goes to IDLE, counters and latched registers clear;
  - every output is 0;
  - no irq_ack is emitted; any partial stack sequence is abandoned.
- busy = stall_fetch = (state != IDLE). Both are combinational from state.
- IDLE, acceptance rules (evaluated at the clock edge):
  - op_valid with op_code != 00 has priority over irq_req.
  - CALL: latch pc_in and call_target, go to PUSH_PC.
  - RET: go to POP_PC.
  - RETI: go to POP_FLAGS.
  - Otherwise, if any irq_req bit is set: latch pc_in, flags_in and the lowest set index; go to DRAIN, or to PUSH_PC if DRAIN_CYCLES=0.
  - irq_req and op_valid are ignored outside IDLE. Pending interrupt levels are re-evaluated on return to IDLE.
- DRAIN: flush=1 for exactly DRAIN_CYCLES cycles, then PUSH_PC.
- Stack handshake:
  - stack_req, stack_we and stack_wdata stay stable until a cycle with stack_ack=1.
  - The word index advances on the ack cycle.
  - stack_req may remain high back-to-back into the next word.
  - stack_ack while stack_req=0 is ignored.
- PUSH_PC: PC_W/WORD_W pushes, most-significant word first.
  - Next state: PUSH_FLAGS for an interrupt, LOAD_PC for CALL.
- PUSH_FLAGS: one push of flags zero-extended to WORD_W, then LOAD_PC.
- POP_FLAGS: one pop. On the ack cycle, register stack_rdata[FLAG_W-1:0]; next cycle, flags_load=1 for one cycle. Then POP_PC.
- POP_PC: PC_W/WORD_W pops, least-significant word first (LIFO). Each word is assembled into its slot on its ack. Then LOAD_PC.
- LOAD_PC: pc_load=1 for one cycle, then IDLE.
  - pc_load_val is call_target (CALL), the assembled PC (RET/RETI), or VEC_BASE + idx*VEC_STRIDE truncated to PC_W (interrupt).
  - For an interrupt, irq_ack[idx]=1 in the same cycle.
- Latency with ack in the same cycle as req, 2 words:
  - CALL: 3 busy cycles.
  - RET: 3 busy cycles.
  - RETI: 5 busy cycles.
  - Interrupt: DRAIN_CYCLES + 4 busy cycles.

Test Plan:
- CALL with pc_in=0x0001_2345, call_target=0x0000_0100, immediate ack -> pushes 0x0001 then 0x2345; then pc_load=1 with pc_load_val=0x00000100; busy for 3 cycles.
- RET with stack_rdata 0x2345 then 0x0001, and stack_ack delayed 3 cycles per word -> stack_req held with stack_we=0 throughout; pc_load_val=0x00012345.
- irq_req=2'b11, flags_in=4'hA, pc_in=0x40 -> flush high for 4 cycles; pushes 0x0000, 0x0040, 0x000A; pc_load_val=0x0 and irq_ack=2'b01.
- RETI with pops 0x000A, 0x0040, 0x0000 -> flags_load=1 with flags_load_val=4'hA; then pc_load_val=0x00000040.
- op_valid CALL and irq_req[1] in the same IDLE cycle -> CALL sequence completes first; the interrupt is then taken with pc_in sampled at that later IDLE cycle, ending in irq_ack=2'b10 and pc_load_val=0x2.
- reset asserted low during the second PUSH_PC word -> all outputs 0 at once; state IDLE; no irq_ack; the next op is accepted normally.
